// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch unit is the master; the memory answers with ack/rdata.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack bus, buffers one
// instruction for IF/ID and handles redirects, including while a fetch is in flight.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    if_fetch_unit_if.master   imem,
    output logic [31:0]       instruction,
    output logic [31:0]       PCp4,
    output logic              valid
);

    typedef enum logic {S_FETCH, S_DRAIN} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_pending, w_pending_next;
    logic [31:0] r_instr, w_instr_next;
    logic [31:0] r_pcp4, w_pcp4_next;
    logic        r_valid, w_valid_next;
    logic        w_req;
    logic        w_xfer;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    assign w_target   = {redirect_pc[31:2], 2'b00};
    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_pending_next = r_pending;
        w_instr_next   = r_instr;
        w_pcp4_next    = r_pcp4;
        w_valid_next   = r_valid;
        w_req          = 1'b0;

        // A held request with valid=1 implies stall=0, so valid clears next
        // cycle and the request stays asserted until acked.
        if (!reset) begin
            w_req = (r_state == S_DRAIN) ? 1'b1 : (!r_valid || !stall);
        end
        w_xfer = w_req && imem.imem_ack;

        case (r_state)
            S_FETCH: begin
                if (redirect) begin
                    w_valid_next = 1'b0;
                    if (w_req && !imem.imem_ack) begin
                        w_pending_next = w_target;
                        w_state_next   = S_DRAIN;
                    end else begin
                        w_pc_next = w_target;
                    end
                end else if (w_xfer) begin
                    w_instr_next = imem.imem_rdata;
                    w_pcp4_next  = w_pc_plus4;
                    w_valid_next = 1'b1;
                    w_pc_next    = w_pc_plus4;
                end else if (r_valid && !stall) begin
                    w_valid_next = 1'b0;
                end
            end
            S_DRAIN: begin
                // The stale response is dropped; a redirect landing on the ack
                // cycle is the newest target and wins.
                if (imem.imem_ack) begin
                    w_pc_next    = redirect ? w_target : r_pending;
                    w_state_next = S_FETCH;
                end else if (redirect) begin
                    w_pending_next = w_target;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_pending <= 32'h0;
            r_instr   <= 32'h0;
            r_pcp4    <= 32'h0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_pending <= w_pending_next;
            r_instr   <= w_instr_next;
            r_pcp4    <= w_pcp4_next;
            r_valid   <= w_valid_next;
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign instruction    = r_instr;
    assign PCp4           = r_pcp4;
    assign valid          = r_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: two instances (reset PC 0 and 0xFFFF_FFFC) in lockstep,
// each with a variable-latency memory, checked every cycle against a reference model.
module tb_if_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    if_fetch_unit_if bus0 ();
    if_fetch_unit_if bus1 ();

    logic [31:0] instr0, instr1, pcp40, pcp41;
    logic        valid0, valid1;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem(bus0),
        .instruction(instr0), .PCp4(pcp40), .valid(valid0)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem(bus1),
        .instruction(instr1), .PCp4(pcp41), .valid(valid1)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h8C01_0000;
    endfunction

    function automatic logic [31:0] reset_pc_of(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
    endfunction

    // Memory: acks after 'lat' waiting cycles; 'spur' raises ack with no request.
    logic [3:0]  lat;
    logic        spur;
    logic [31:0] junk;
    logic [3:0]  mcnt [2];

    logic        req_s   [2];
    logic [31:0] addr_s  [2];
    logic        ack_s   [2];
    logic [31:0] instr_s [2];
    logic [31:0] pcp4_s  [2];
    logic        valid_s [2];

    assign bus0.imem_ack   = bus0.imem_req ? (mcnt[0] >= lat) : spur;
    assign bus1.imem_ack   = bus1.imem_req ? (mcnt[1] >= lat) : spur;
    assign bus0.imem_rdata = bus0.imem_ack ? data_of(bus0.imem_addr) : junk;
    assign bus1.imem_rdata = bus1.imem_ack ? data_of(bus1.imem_addr) : junk;

    assign req_s[0]   = bus0.imem_req;
    assign req_s[1]   = bus1.imem_req;
    assign addr_s[0]  = bus0.imem_addr;
    assign addr_s[1]  = bus1.imem_addr;
    assign ack_s[0]   = bus0.imem_ack;
    assign ack_s[1]   = bus1.imem_ack;
    assign instr_s[0] = instr0;
    assign instr_s[1] = instr1;
    assign pcp4_s[0]  = pcp40;
    assign pcp4_s[1]  = pcp41;
    assign valid_s[0] = valid0;
    assign valid_s[1] = valid1;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || !req_s[i] || ack_s[i]) mcnt[i] <= 4'd0;
            else                                mcnt[i] <= mcnt[i] + 4'd1;
        end
    end

    // Reference model: the architectural PC, the one-entry buffer, and whether
    // a request already issued is doomed to be thrown away (with the PC to resume at).
    logic [31:0] m_pc    [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_pcp4  [2];
    logic [31:0] m_resume[2];
    bit          m_valid [2];
    bit          m_doomed[2];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset(input int i);
        m_pc[i]     = reset_pc_of(i);
        m_instr[i]  = 32'h0;
        m_pcp4[i]   = 32'h0;
        m_resume[i] = 32'h0;
        m_valid[i]  = 1'b0;
        m_doomed[i] = 1'b0;
    endtask

    // One clock: compare everything at mid-cycle, advance the model, step past the edge.
    task automatic cycle();
        bit          exp_req;
        logic [31:0] tgt;
        @(negedge clk);
        #1;
        tgt = redirect_pc & 32'hFFFF_FFFC;
        for (int i = 0; i < 2; i++) begin
            exp_req = !reset && (m_doomed[i] || !m_valid[i] || !stall);
            chk($sformatf("imem_req[%0d]", i), {31'b0, req_s[i]}, {31'b0, exp_req});
            chk($sformatf("imem_addr[%0d]", i), addr_s[i], m_pc[i]);
            chk($sformatf("valid[%0d]", i), {31'b0, valid_s[i]}, {31'b0, m_valid[i]});
            chk($sformatf("instruction[%0d]", i), instr_s[i], m_instr[i]);
            chk($sformatf("PCp4[%0d]", i), pcp4_s[i], m_pcp4[i]);
            if (m_valid[i])
                chk($sformatf("instr_of_pc[%0d]", i), instr_s[i], data_of(pcp4_s[i] - 32'd4));

            if (reset) begin
                model_reset(i);
            end else if (m_doomed[i]) begin
                if (ack_s[i]) begin
                    m_doomed[i] = 1'b0;
                    m_pc[i]     = redirect ? tgt : m_resume[i];
                end else if (redirect) begin
                    m_resume[i] = tgt;
                end
            end else if (redirect) begin
                m_valid[i] = 1'b0;
                if (exp_req && !ack_s[i]) begin
                    m_doomed[i] = 1'b1;
                    m_resume[i] = tgt;
                end else begin
                    m_pc[i] = tgt;
                end
            end else if (exp_req && ack_s[i]) begin
                m_instr[i] = data_of(m_pc[i]);
                m_pc[i]    = m_pc[i] + 32'd4;
                m_pcp4[i]  = m_pc[i];
                m_valid[i] = 1'b1;
            end else if (m_valid[i] && !stall) begin
                m_valid[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        lat = 4'd0; spur = 1'b0; junk = 32'hBAD0_BAD0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) model_reset(i);
        cycle();
        reset = 1'b0;

        // Zero-wait streaming; second instance wraps from 0xFFFF_FFFC.
        cycle();
        chk("stream_pcp4_0", pcp40, 32'h4);
        chk("wrap_pcp4", pcp41, 32'h0);
        chk("wrap_next_addr", bus1.imem_addr, 32'h0);
        cycle();
        chk("stream_instr_1", instr0, 32'h8C01_0004);
        chk("stream_pcp4_1", pcp40, 32'h8);

        // Stall holds the buffer and suppresses requests.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_req", {31'b0, bus0.imem_req}, 32'h0);
            chk("stall_instr", instr0, 32'h8C01_0004);
            chk("stall_pcp4", pcp40, 32'h8);
        end
        stall = 1'b0;
        cycle();
        chk("resume_pcp4", pcp40, 32'hC);

        // Redirect while a slow request is outstanding.
        lat = 4'd3;
        cycle();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        redirect = 1'b0;
        chk("drain_addr_held", bus0.imem_addr, 32'hC);
        chk("drain_valid", {31'b0, valid0}, 32'h0);
        cycle();
        cycle();
        chk("drain_new_addr", bus0.imem_addr, 32'h100);
        chk("drain_valid_after", {31'b0, valid0}, 32'h0);
        lat = 4'd0;
        cycle();
        chk("after_drain_pcp4", pcp40, 32'h104);
        cycle();

        // Redirect with stall=1 and a live instruction; low target bits dropped.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0042;
        cycle();
        stall = 1'b0; redirect = 1'b0;
        chk("redir_stall_valid", {31'b0, valid0}, 32'h0);
        chk("redir_stall_addr", bus0.imem_addr, 32'h40);

        // Reset in the middle of a drain.
        lat = 4'd3;
        cycle();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        cycle();
        redirect = 1'b0; reset = 1'b1;
        cycle();
        chk("rst_drain_addr", bus0.imem_addr, 32'h0);
        chk("rst_drain_req", {31'b0, bus0.imem_req}, 32'h0);
        chk("rst_drain_valid", {31'b0, valid0}, 32'h0);
        reset = 1'b0; lat = 4'd0;
        repeat (3) cycle();

        // Randomised traffic.
        for (int n = 0; n < 800; n++) begin
            stall       = ($urandom_range(0, 2) == 0);
            redirect    = ($urandom_range(0, 7) == 0);
            redirect_pc = $urandom;
            spur        = ($urandom_range(0, 3) == 0);
            junk        = $urandom;
            reset       = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) == 0) lat = 4'($urandom_range(0, 3));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
